dsp_mac_nx: RTL
===============

# dsp_mac_nx

Parametrised N-channel multiply / multiply-accumulate DSP block, the generalised successor of the fixed dual 10x9 DSP primitive wrapper. Each channel multiplies an A operand (port or runtime-writable coefficient bank) by B, then optionally accumulates, rounds, shifts and saturates. A valid-qualified pipeline with configurable input/output registering replaces the fixed per-mode sub-primitive selection. It sits in the DSP primitive library between user RTL and the fabric DSP tiles.

## Interface
- NUM_CH, 2, number of independent channels (1-8)
- A_WIDTH, 10, A operand / coefficient width
- B_WIDTH, 9, B operand width
- ACC_WIDTH, 32, accumulator width (>= A_WIDTH+B_WIDTH+1)
- Z_WIDTH, 19, per-channel result width (<= ACC_WIDTH)
- DSP_MODE, "MULTIPLY_ACCUMULATE", "MULTIPLY" or "MULTIPLY_ACCUMULATE"; other values: $display error and $stop at elaboration
- INPUT_REG_EN, "TRUE", register all inputs (TRUE/FALSE)
- OUTPUT_REG_EN, "TRUE", register Z/VALID_OUT (TRUE/FALSE)
- COEFF_INIT, 0, NUM_CH*4*A_WIDTH bits; channel c coefficient k at bits [(c*4+k)*A_WIDTH +: A_WIDTH]

- CLK  input  1  clock, all state on rising edge
- RESET  input  1  asynchronous, active-low reset
- VALID_IN  input  1  qualifies A, B and per-sample controls
- A  input  NUM_CH*A_WIDTH  channel c at [c*A_WIDTH +: A_WIDTH]
- B  input  NUM_CH*B_WIDTH  channel c at [c*B_WIDTH +: B_WIDTH]
- FEEDBACK  input  3  bit2=1: A operand = coefficient FEEDBACK[1:0]; bit2=0: A port
- UNSIGNED_A, UNSIGNED_B  input  1 each  operand signedness
- LOAD_ACC  input  1  restart accumulation with current product
- SUBTRACT  input  1  accumulate/load negated product
- SHIFT_RIGHT  input  5  arithmetic right shift of accumulator at output
- ROUND  input  1  round-half-up before shift
- SATURATE  input  1  clamp to Z range instead of truncate
- COEFF_WE  input  1  coefficient write strobe
- COEFF_CH  input  3  target channel (>= NUM_CH: write ignored)
- COEFF_ADDR  input  2  coefficient index
- COEFF_DATA  input  A_WIDTH  write data
- Z  output  NUM_CH*Z_WIDTH  results, channel c at [c*Z_WIDTH +: Z_WIDTH]
- VALID_OUT  output  1  Z holds a new result
- DLY_B  output  NUM_CH*B_WIDTH  B delayed one valid sample

## Operation
- Product per channel: A-operand and B extended per UNSIGNED_A/UNSIGNED_B to A_WIDTH+B_WIDTH+1 signed bits, multiplied, sign-extended to ACC_WIDTH.
- MULTIPLY mode: Z = low Z_WIDTH bits of product; LOAD_ACC, SUBTRACT, SHIFT_RIGHT, ROUND, SATURATE ignored.
- MULTIPLY_ACCUMULATE: accumulator register per channel, updated only on valid samples. LOAD_ACC=1: acc = SUBTRACT ? -p : p; else acc = acc ± p, wrapping modulo 2^ACC_WIDTH.
- Output path (ACC mode): if ROUND and SHIFT_RIGHT>0, add 2^(SHIFT_RIGHT-1); arithmetic shift right; SATURATE=1 clamps to signed Z range, or [0, 2^Z_WIDTH-1] when both UNSIGNED flags set; SATURATE=0 keeps low Z_WIDTH bits. Output controls are taken from the sample that produced the accumulator value.
- Coefficient bank: NUM_CH x 4 registers, loaded from COEFF_INIT on reset; COEFF_WE writes on the clock edge; a read of the same entry in that cycle returns the old value. Writes are not gated by VALID_IN.
- DLY_B: per channel, captures B (post input register) on each valid sample.
- Idle cycles (VALID_IN=0): data registers hold, accumulator holds, VALID_OUT deasserts after the pipeline drains.

## Timing
- Latency L = (INPUT_REG_EN=="TRUE") + (ACC mode ? 1 : 0) + (OUTPUT_REG_EN=="TRUE"); VALID_OUT follows VALID_IN by exactly L cycles. L=0 is fully combinational (VALID_OUT = VALID_IN).
- Throughput one sample per cycle per channel; no back-pressure.
- Reset (asserted at any time, including mid-accumulation): Z=0, VALID_OUT=0, DLY_B=0, accumulators=0, all pipeline registers and valid bits=0, coefficients=COEFF_INIT. In-flight samples are discarded. The first valid after deassertion starts a fresh accumulation even with LOAD_ACC=0.

## Test plan
- Default params, MULTIPLY_ACCUMULATE, signed: ch0 A=3,B=-2 with LOAD_ACC=1, then two samples A=3,B=4 -> ch0 Z sequence -6, 6, 18; VALID_OUT exactly 3 cycles after each VALID_IN.
- Saturation: Z_WIDTH=19, A=511, B=255 accumulated 8 times, SATURATE=1 -> Z clamps to 262143; SATURATE=0 -> low 19 bits of 1042440 (= 0x7E808).
- Round/shift: acc=13, SHIFT_RIGHT=2, ROUND=1 -> Z=3; ROUND=0 -> Z=3; acc=-6, SHIFT_RIGHT=2, ROUND=1 -> Z=-1 (0x7FFFF).
- Coefficients: write ch1 coeff2=100, same-cycle sample FEEDBACK=3'b110, B=2 -> product from old value (COEFF_INIT); next sample -> product 200; write with COEFF_CH=5 -> no change.
- MULTIPLY mode, INPUT_REG_EN=OUTPUT_REG_EN="FALSE", UNSIGNED_A=UNSIGNED_B=1, A=1023, B=511 -> Z=522753 combinationally, VALID_OUT=VALID_IN.
- Reset mid-accumulation after 3 samples, with VALID_IN bubbles -> Z, VALID_OUT, DLY_B=0 immediately; next sample A=2,B=2, LOAD_ACC=0 -> Z=4.

Source files
------------

// File: rtl/dsp_mac_nx.sv
// dsp_mac_nx: N-channel multiply / multiply-accumulate DSP block.
// Per channel: (A port | coefficient) x B -> accumulate -> round/shift/saturate -> Z.
//
// Parameters:
//   NUM_CH        number of channels (1-8)
//   A_WIDTH       A operand / coefficient width
//   B_WIDTH       B operand width
//   ACC_WIDTH     accumulator width (>= A_WIDTH+B_WIDTH+1)
//   Z_WIDTH       per-channel result width (<= ACC_WIDTH)
//   DSP_MODE      "MULTIPLY" or "MULTIPLY_ACCUMULATE"
//   INPUT_REG_EN  "TRUE": register every input sample
//   OUTPUT_REG_EN "TRUE": register Z / VALID_OUT
//   COEFF_INIT    reset image of the coefficient bank
//
// Ports:
//   CLK, RESET (async, active-low)
//   VALID_IN                      qualifies A, B and per-sample controls
//   A, B                          packed per-channel operands
//   FEEDBACK[2:0]                 bit2: A operand from coefficient FEEDBACK[1:0]
//   UNSIGNED_A, UNSIGNED_B        operand signedness
//   LOAD_ACC, SUBTRACT            accumulator restart / negate product
//   SHIFT_RIGHT, ROUND, SATURATE  output conditioning
//   COEFF_WE/CH/ADDR/DATA         coefficient bank write port
//   Z, VALID_OUT                  packed results and their qualifier
//   DLY_B                         B delayed by one valid sample
module dsp_mac_nx #(
    parameter int    NUM_CH        = 2,
    parameter int    A_WIDTH       = 10,
    parameter int    B_WIDTH       = 9,
    parameter int    ACC_WIDTH     = 32,
    parameter int    Z_WIDTH       = 19,
    parameter string DSP_MODE      = "MULTIPLY_ACCUMULATE",
    parameter string INPUT_REG_EN  = "TRUE",
    parameter string OUTPUT_REG_EN = "TRUE",
    parameter logic [NUM_CH*4*A_WIDTH-1:0] COEFF_INIT = '0
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        VALID_IN,
    input  logic [NUM_CH*A_WIDTH-1:0]   A,
    input  logic [NUM_CH*B_WIDTH-1:0]   B,
    input  logic [2:0]                  FEEDBACK,
    input  logic                        UNSIGNED_A,
    input  logic                        UNSIGNED_B,
    input  logic                        LOAD_ACC,
    input  logic                        SUBTRACT,
    input  logic [4:0]                  SHIFT_RIGHT,
    input  logic                        ROUND,
    input  logic                        SATURATE,
    input  logic                        COEFF_WE,
    input  logic [2:0]                  COEFF_CH,
    input  logic [1:0]                  COEFF_ADDR,
    input  logic [A_WIDTH-1:0]          COEFF_DATA,
    output logic [NUM_CH*Z_WIDTH-1:0]   Z,
    output logic                        VALID_OUT,
    output logic [NUM_CH*B_WIDTH-1:0]   DLY_B
);

    localparam bit IS_ACC  = (DSP_MODE == "MULTIPLY_ACCUMULATE");
    localparam bit IS_MUL  = (DSP_MODE == "MULTIPLY");
    localparam bit IN_REG  = (INPUT_REG_EN == "TRUE");
    localparam bit OUT_REG = (OUTPUT_REG_EN == "TRUE");

    localparam int AV = NUM_CH * A_WIDTH;
    localparam int BV = NUM_CH * B_WIDTH;
    localparam int ZV = NUM_CH * Z_WIDTH;
    localparam int PV = NUM_CH * ACC_WIDTH;

    // One guard bit so rounding cannot wrap the accumulator value.
    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic signed [EW-1:0] SMAX = (ONE <<< (Z_WIDTH - 1)) - ONE;
    localparam logic signed [EW-1:0] SMIN = -(ONE <<< (Z_WIDTH - 1));
    localparam logic signed [EW-1:0] UMAX = (ONE <<< Z_WIDTH) - ONE;

    if (!(IS_ACC || IS_MUL)) begin : g_bad_mode
        $error("dsp_mac_nx: unsupported DSP_MODE %s", DSP_MODE);
    end

    logic [AV-1:0] a_mux;
    logic [AV-1:0] s1_a;
    logic [BV-1:0] s1_b;
    logic          s1_valid;
    logic          s1_ua;
    logic          s1_ub;
    logic          s1_load;
    logic          s1_sub;
    logic [4:0]    s1_sh;
    logic          s1_rnd;
    logic          s1_sat;
    logic [PV-1:0] p_vec;
    logic [ZV-1:0] z_calc;
    logic          v_calc;

    // Coefficient bank, operand select and product per channel.
    // The operand is selected before the input register, so a write
    // landing on the same edge is not yet visible to that sample.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [A_WIDTH-1:0]          coeff [4];
        logic [A_WIDTH-1:0]          a_op;
        logic [B_WIDTH-1:0]          b_op;
        logic signed [ACC_WIDTH-1:0] ax;
        logic signed [ACC_WIDTH-1:0] bx;

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                for (int k = 0; k < 4; k++) begin
                    coeff[k] <= COEFF_INIT[(c*4+k)*A_WIDTH +: A_WIDTH];
                end
            end else if (COEFF_WE && COEFF_CH == 3'(c)) begin
                coeff[COEFF_ADDR] <= COEFF_DATA;
            end
        end

        assign a_mux[c*A_WIDTH +: A_WIDTH] =
            FEEDBACK[2] ? coeff[FEEDBACK[1:0]] : A[c*A_WIDTH +: A_WIDTH];

        assign a_op = s1_a[c*A_WIDTH +: A_WIDTH];
        assign b_op = s1_b[c*B_WIDTH +: B_WIDTH];

        // Extending straight to ACC_WIDTH keeps the product exact,
        // since it always fits in A_WIDTH+B_WIDTH+1 bits.
        assign ax = {{(ACC_WIDTH-A_WIDTH){~s1_ua & a_op[A_WIDTH-1]}}, a_op};
        assign bx = {{(ACC_WIDTH-B_WIDTH){~s1_ub & b_op[B_WIDTH-1]}}, b_op};
        assign p_vec[c*ACC_WIDTH +: ACC_WIDTH] = ax * bx;
    end

    // Input stage: data holds across idle cycles, valid always follows.
    if (IN_REG) begin : g_ireg
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                s1_valid <= 1'b0;
                s1_a     <= '0;
                s1_b     <= '0;
                s1_ua    <= 1'b0;
                s1_ub    <= 1'b0;
                s1_load  <= 1'b0;
                s1_sub   <= 1'b0;
                s1_sh    <= '0;
                s1_rnd   <= 1'b0;
                s1_sat   <= 1'b0;
            end else begin
                s1_valid <= VALID_IN;
                if (VALID_IN) begin
                    s1_a    <= a_mux;
                    s1_b    <= B;
                    s1_ua   <= UNSIGNED_A;
                    s1_ub   <= UNSIGNED_B;
                    s1_load <= LOAD_ACC;
                    s1_sub  <= SUBTRACT;
                    s1_sh   <= SHIFT_RIGHT;
                    s1_rnd  <= ROUND;
                    s1_sat  <= SATURATE;
                end
            end
        end
    end else begin : g_icomb
        assign s1_valid = VALID_IN;
        assign s1_a     = a_mux;
        assign s1_b     = B;
        assign s1_ua    = UNSIGNED_A;
        assign s1_ub    = UNSIGNED_B;
        assign s1_load  = LOAD_ACC;
        assign s1_sub   = SUBTRACT;
        assign s1_sh    = SHIFT_RIGHT;
        assign s1_rnd   = ROUND;
        assign s1_sat   = SATURATE;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DLY_B <= '0;
        end else if (s1_valid) begin
            DLY_B <= s1_b;
        end
    end

    if (IS_ACC) begin : g_mac
        // Output conditioning travels with the sample that set the acc.
        logic       s2_valid;
        logic [4:0] s2_sh;
        logic       s2_rnd;
        logic       s2_sat;
        logic       s2_uns;

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                s2_valid <= 1'b0;
                s2_sh    <= '0;
                s2_rnd   <= 1'b0;
                s2_sat   <= 1'b0;
                s2_uns   <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sh  <= s1_sh;
                    s2_rnd <= s1_rnd;
                    s2_sat <= s1_sat;
                    s2_uns <= s1_ua & s1_ub;
                end
            end
        end

        assign v_calc = s2_valid;

        for (genvar c = 0; c < NUM_CH; c++) begin : g_acc
            logic signed [ACC_WIDTH-1:0] p;
            logic signed [ACC_WIDTH-1:0] p_n;
            logic signed [ACC_WIDTH-1:0] base;
            logic signed [ACC_WIDTH-1:0] acc;
            logic signed [EW-1:0]        ext;
            logic signed [EW-1:0]        rnd;
            logic signed [EW-1:0]        sum;
            logic signed [EW-1:0]        shd;
            logic signed [EW-1:0]        hi;
            logic signed [EW-1:0]        lo;
            logic [Z_WIDTH-1:0]          zc;

            assign p    = p_vec[c*ACC_WIDTH +: ACC_WIDTH];
            assign p_n  = s1_sub ? -p : p;
            assign base = s1_load ? '0 : acc;

            // Reset clears acc, so the first sample after reset
            // starts a fresh sum even without LOAD_ACC.
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    acc <= '0;
                end else if (s1_valid) begin
                    acc <= base + p_n;
                end
            end

            assign ext = {acc[ACC_WIDTH-1], acc};
            assign rnd = (s2_rnd && s2_sh != 5'd0)
                       ? (ONE <<< (s2_sh - 5'd1)) : '0;
            assign sum = ext + rnd;
            assign shd = sum >>> s2_sh;
            assign hi  = s2_uns ? UMAX : SMAX;
            assign lo  = s2_uns ? '0 : SMIN;

            always_comb begin
                zc = shd[Z_WIDTH-1:0];
                if (s2_sat) begin
                    if (shd > hi) begin
                        zc = hi[Z_WIDTH-1:0];
                    end else if (shd < lo) begin
                        zc = lo[Z_WIDTH-1:0];
                    end
                end
            end

            assign z_calc[c*Z_WIDTH +: Z_WIDTH] = zc;
        end
    end else begin : g_mul
        logic unused_mul;

        assign v_calc = s1_valid;
        assign unused_mul = ^{s1_load, s1_sub, s1_sh, s1_rnd, s1_sat, p_vec};

        for (genvar c = 0; c < NUM_CH; c++) begin : g_z
            assign z_calc[c*Z_WIDTH +: Z_WIDTH] =
                p_vec[c*ACC_WIDTH +: Z_WIDTH];
        end
    end

    if (OUT_REG) begin : g_oreg
        logic [ZV-1:0] z_q;
        logic          v_q;

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                z_q <= '0;
                v_q <= 1'b0;
            end else begin
                v_q <= v_calc;
                if (v_calc) begin
                    z_q <= z_calc;
                end
            end
        end

        assign Z         = z_q;
        assign VALID_OUT = v_q;
    end else begin : g_ocomb
        assign Z         = z_calc;
        assign VALID_OUT = v_calc;
    end

endmodule
